// File: rtl/lcd_bus_writer.sv
// HD44780-style character-LCD bus writer: 4/8-bit bus, single-nibble init writes,
// programmable setup/enable/hold/gap timing and automatic long wait for clear/home.
module lcd_bus_writer #(
    parameter bit          BUS8    = 1'b0,
    parameter int unsigned DW      = BUS8 ? 8 : 4,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 12,
    parameter int unsigned T_GAP   = 27,
    parameter int unsigned T_CMD   = 1080,
    parameter int unsigned T_LONG  = 44280,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Strb,
    input  logic          RS,
    input  logic          Nibble_only,
    input  logic [7:0]    D_in,
    output logic          Busy,
    output logic          Done,
    output logic          E,
    output logic          RS_out,
    output logic          RW_out,
    output logic [DW-1:0] D_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ENABLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4,
        ST_WAIT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long(input logic rs, input logic [7:0] d);
        return (!rs) && ((d == 8'h01) || (d[7:1] == 7'h01));
    endfunction

    // Top DW bits: the high nibble on a 4-bit bus, the whole byte on an 8-bit bus.
    function automatic logic [DW-1:0] first_xfer(input logic [7:0] d);
        return d[7:8-DW];
    endfunction

    function automatic logic [DW-1:0] second_xfer(input logic [7:0] d);
        return d[DW-1:0];
    endfunction

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [7:0]        d_r, d_s;
    logic              long_r, long_s;
    logic              nib2_r, nib2_s;
    logic              second_r, second_s;
    logic              e_s, busy_s, done_s, rs_out_s;
    logic [DW-1:0]     d_out_s;

    // Next-state, counter reload and next output values.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        d_s      = d_r;
        long_s   = long_r;
        nib2_s   = nib2_r;
        second_s = second_r;
        rs_out_s = RS_out;
        d_out_s  = D_out;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Strb) begin
                    state_s  = ST_SETUP;
                    cnt_s    = LD_SETUP;
                    d_s      = D_in;
                    long_s   = is_long(RS, D_in);
                    nib2_s   = (!BUS8) && (!Nibble_only);
                    second_s = 1'b0;
                    rs_out_s = RS;
                    d_out_s  = first_xfer(D_in);
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_ENABLE;
                    cnt_s   = LD_EN;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_ENABLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_HOLD;
                    cnt_s   = LD_HOLD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    if (nib2_r && !second_r) begin
                        state_s = ST_GAP;
                        cnt_s   = LD_GAP;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = long_r ? LD_LONG : LD_CMD;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s  = ST_SETUP;
                    cnt_s    = LD_SETUP;
                    second_s = 1'b1;
                    d_out_s  = second_xfer(d_r);
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        // E follows the registered state so it can never overlap a data change.
        e_s    = (state_s == ST_ENABLE);
        busy_s = (state_s != ST_IDLE);
    end

    // State, counter, captured request and registered pin outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            d_r      <= 8'h00;
            long_r   <= 1'b0;
            nib2_r   <= 1'b0;
            second_r <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            E        <= 1'b0;
            RS_out   <= 1'b0;
            RW_out   <= 1'b0;
            D_out    <= {DW{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            d_r      <= d_s;
            long_r   <= long_s;
            nib2_r   <= nib2_s;
            second_r <= second_s;
            Busy     <= busy_s;
            Done     <= done_s;
            E        <= e_s;
            RS_out   <= rs_out_s;
            RW_out   <= 1'b0;
            D_out    <= d_out_s;
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: directed table, hand sequences and random writes on
// four instances (short-timing 4/8-bit, default-timing 4/8-bit) against a timeline model.
module tb_lcd_bus_writer;

    localparam int S_TS = 2, S_TE = 3, S_TH = 2, S_TG = 4, S_TC = 6, S_TL = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] strb;
    logic       rs, nib;
    logic [7:0] din;
    logic [3:0] e_v, busy_v, done_v, rso_v, rw_v;
    logic [3:0][7:0] dout_v;
    logic [3:0] d0, d2;
    logic [7:0] d1, d3;

    int total = 0;
    int bad   = 0;
    int p_ts[4], p_te[4], p_th[4], p_tg[4], p_tc[4], p_tl[4];
    bit p_b8[4];

    lcd_bus_writer #(.BUS8(1'b0), .T_SETUP(S_TS), .T_EN(S_TE), .T_HOLD(S_TH), .T_GAP(S_TG),
                     .T_CMD(S_TC), .T_LONG(S_TL), .CNT_W(8)) u0 (
        .Clk(clk), .Reset(reset), .Strb(strb[0]), .RS(rs), .Nibble_only(nib), .D_in(din),
        .Busy(busy_v[0]), .Done(done_v[0]), .E(e_v[0]), .RS_out(rso_v[0]), .RW_out(rw_v[0]), .D_out(d0));
    lcd_bus_writer #(.BUS8(1'b1), .T_SETUP(S_TS), .T_EN(S_TE), .T_HOLD(S_TH), .T_GAP(S_TG),
                     .T_CMD(S_TC), .T_LONG(S_TL), .CNT_W(8)) u1 (
        .Clk(clk), .Reset(reset), .Strb(strb[1]), .RS(rs), .Nibble_only(nib), .D_in(din),
        .Busy(busy_v[1]), .Done(done_v[1]), .E(e_v[1]), .RS_out(rso_v[1]), .RW_out(rw_v[1]), .D_out(d1));
    lcd_bus_writer #(.BUS8(1'b0)) u2 (
        .Clk(clk), .Reset(reset), .Strb(strb[2]), .RS(rs), .Nibble_only(nib), .D_in(din),
        .Busy(busy_v[2]), .Done(done_v[2]), .E(e_v[2]), .RS_out(rso_v[2]), .RW_out(rw_v[2]), .D_out(d2));
    lcd_bus_writer #(.BUS8(1'b1)) u3 (
        .Clk(clk), .Reset(reset), .Strb(strb[3]), .RS(rs), .Nibble_only(nib), .D_in(din),
        .Busy(busy_v[3]), .Done(done_v[3]), .E(e_v[3]), .RS_out(rso_v[3]), .RW_out(rw_v[3]), .D_out(d3));

    assign dout_v[0] = {4'h0, d0};
    assign dout_v[1] = d1;
    assign dout_v[2] = {4'h0, d2};
    assign dout_v[3] = d3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one write on instance k (called at a negedge) and compare every cycle of
    // the busy window plus the Done cycle against the timeline derived from the timing rules.
    task automatic write_check(input int k, input logic rs_i, input logic nib_i, input logic [7:0] d_i,
                               input bit keep, input string tag, output int busy_meas);
        bit nib2, lng, exp_e;
        int x, tw, blen, t2;
        int bad_e, bad_b, bad_dn, bad_d, bad_rs, bad_rw;
        logic [7:0] first, second, exp_d;
        din = d_i; rs = rs_i; nib = nib_i; strb[k] = 1'b1;
        nib2  = !p_b8[k] && !nib_i;
        lng   = !rs_i && (d_i inside {8'h01, 8'h02, 8'h03});
        first = p_b8[k] ? d_i : {4'h0, d_i[7:4]};
        second = {4'h0, d_i[3:0]};
        x    = p_ts[k] + p_te[k] + p_th[k];
        tw   = lng ? p_tl[k] : p_tc[k];
        t2   = x + p_tg[k];
        blen = nib2 ? 2 * x + p_tg[k] + tw : x + tw;
        busy_meas = 0;
        bad_e = 0; bad_b = 0; bad_dn = 0; bad_d = 0; bad_rs = 0; bad_rw = 0;
        @(posedge clk);
        for (int c = 0; c <= blen; c++) begin
            @(negedge clk);
            if (c == 0 && !keep) strb[k] = 1'b0;
            exp_e = (c >= p_ts[k] && c < p_ts[k] + p_te[k]) ||
                    (nib2 && c >= t2 + p_ts[k] && c < t2 + p_ts[k] + p_te[k]);
            exp_d = (nib2 && c >= t2) ? second : first;
            if (busy_v[k] === 1'b1) busy_meas++;
            if (e_v[k] !== exp_e) bad_e++;
            if (busy_v[k] !== (c < blen)) bad_b++;
            if (done_v[k] !== (c == blen)) bad_dn++;
            if (dout_v[k] !== exp_d) bad_d++;
            if (rso_v[k] !== rs_i) bad_rs++;
            if (rw_v[k] !== 1'b0) bad_rw++;
        end
        check({tag, ".E_bad_cycles"}, bad_e, 0);
        check({tag, ".Busy_bad_cycles"}, bad_b, 0);
        check({tag, ".Done_bad_cycles"}, bad_dn, 0);
        check({tag, ".D_out_bad_cycles"}, bad_d, 0);
        check({tag, ".RS_out_bad_cycles"}, bad_rs, 0);
        check({tag, ".RW_out_bad_cycles"}, bad_rw, 0);
    endtask

    typedef struct {
        int         k;
        logic       rs;
        logic       nib;
        logic [7:0] d;
        int         busy;
    } vec_t;

    vec_t tbl[14];
    int   m, cnt_b, cnt_d;

    initial begin
        p_ts = '{S_TS, S_TS, 2, 2};         p_te = '{S_TE, S_TE, 12, 12};
        p_th = '{S_TH, S_TH, 12, 12};       p_tg = '{S_TG, S_TG, 27, 27};
        p_tc = '{S_TC, S_TC, 1080, 1080};   p_tl = '{S_TL, S_TL, 44280, 44280};
        p_b8 = '{1'b0, 1'b1, 1'b0, 1'b1};

        tbl[0]  = '{2, 1'b1, 1'b0, 8'h41, 1159};
        tbl[1]  = '{2, 1'b0, 1'b0, 8'h01, 44359};
        tbl[2]  = '{2, 1'b0, 1'b1, 8'h30, 1106};
        tbl[3]  = '{3, 1'b1, 1'b1, 8'hA5, 1106};
        tbl[4]  = '{0, 1'b0, 1'b0, 8'h01, 33};
        tbl[5]  = '{0, 1'b0, 1'b0, 8'h02, 33};
        tbl[6]  = '{0, 1'b0, 1'b0, 8'h03, 33};
        tbl[7]  = '{0, 1'b0, 1'b0, 8'h04, 24};
        tbl[8]  = '{0, 1'b1, 1'b0, 8'h01, 24};
        tbl[9]  = '{0, 1'b0, 1'b1, 8'h02, 22};
        tbl[10] = '{0, 1'b0, 1'b1, 8'h30, 13};
        tbl[11] = '{1, 1'b1, 1'b1, 8'hA5, 13};
        tbl[12] = '{1, 1'b0, 1'b0, 8'h03, 22};
        tbl[13] = '{1, 1'b0, 1'b0, 8'h00, 13};

        reset = 1'b1; strb = 4'h0; rs = 1'b0; nib = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("reset_state%0d", k),
                  {19'h0, e_v[k], busy_v[k], done_v[k], rso_v[k], rw_v[k], dout_v[k]}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            write_check(tbl[i].k, tbl[i].rs, tbl[i].nib, tbl[i].d, 1'b0, $sformatf("tbl%0d", i), m);
            check($sformatf("tbl%0d.busy_len", i), m, tbl[i].busy);
        end

        // Strb held through a whole write, then a new request in the Done cycle.
        write_check(0, 1'b1, 1'b0, 8'h5A, 1'b1, "hold", m);
        write_check(0, 1'b1, 1'b0, 8'hC3, 1'b0, "b2b", m);
        check("b2b.busy_len", m, 24);
        cnt_b = 0;
        repeat (5) begin @(negedge clk); if (busy_v[0] !== 1'b0) cnt_b++; end
        check("b2b.no_extra_write", cnt_b, 0);

        // Reset while E is high on the first nibble.
        din = 8'h96; rs = 1'b1; nib = 1'b0; strb[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        strb[0] = 1'b0;
        repeat (S_TS) @(negedge clk);
        check("rst.E_before", e_v[0], 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst.outputs_after", {e_v[0], busy_v[0], done_v[0]}, 3'b000);
        reset = 1'b0;
        cnt_b = 0; cnt_d = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_v[0] !== 1'b0) cnt_b++;
            if (done_v[0] !== 1'b0) cnt_d++;
        end
        check("rst.no_busy", cnt_b, 0);
        check("rst.no_done", cnt_d, 0);
        write_check(0, 1'b0, 1'b0, 8'h28, 1'b0, "after_rst", m);

        // Random writes on the short-timing instances.
        for (int i = 0; i < 150; i++) begin
            int k;
            logic r_rs, r_nib;
            logic [7:0] r_d;
            bit keep;
            k     = $urandom_range(0, 1);
            r_rs  = 1'($urandom);
            r_nib = 1'($urandom);
            r_d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            keep  = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            write_check(k, r_rs, r_nib, r_d, keep, $sformatf("rnd%0d", i), m);
            if (keep) begin
                r_d = 8'($urandom);
                write_check(k, 1'($urandom), 1'($urandom), r_d, 1'b0, $sformatf("rnd%0d_b2b", i), m);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
